// File: rtl/ex_module.sv
// Execute stage: single-cycle ALU into a registered exbus, plus an iterative shift-add multiplier.
// Latency 1 cycle for ALU ops, 18 cycles for MUL; ex_stall holds decode for the first 17 MUL cycles.
module ex_module (
    input  logic        clock,
    input  logic        resetn,
    input  logic [55:0] idbus,
    output logic [39:0] exbus,
    output logic [2:0]  ex_dest,
    output logic        ex_stall
);
    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010,
                           OP_OR  = 4'b0011, OP_XOR = 4'b0100, OP_SLL = 4'b0101,
                           OP_SRL = 4'b0110, OP_SRA = 4'b0111, OP_SLT = 4'b1000,
                           OP_MUL = 4'b1001, OP_LD  = 4'b1010, OP_ST  = 4'b1011,
                           OP_LI  = 4'b1100;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    logic        w_vld;
    logic [3:0]  w_op;
    logic [2:0]  w_dest;
    logic [15:0] w_a, w_b, w_stv, w_res;
    logic        w_mul_req;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [15:0] r_acc, r_mcand, r_mplier, r_stv;
    logic [2:0]  r_dest;
    logic [39:0] r_exbus;

    assign w_vld  = idbus[55];
    assign w_op   = idbus[54:51];
    assign w_dest = idbus[50:48];
    assign w_a    = idbus[47:32];
    assign w_b    = idbus[31:16];
    assign w_stv  = idbus[15:0];

    assign w_mul_req = w_vld && (w_op == OP_MUL);
    assign ex_dest   = w_dest;
    assign exbus     = r_exbus;
    // Gated by resetn so a held MUL on idbus cannot stall decode during reset.
    assign ex_stall  = resetn && ((r_state == BUSY) || ((r_state == IDLE) && w_mul_req));

    always_comb begin
        w_res = 16'h0000;
        case (w_op)
            OP_ADD:        w_res = w_a + w_b;
            OP_SUB:        w_res = w_a - w_b;
            OP_AND:        w_res = w_a & w_b;
            OP_OR:         w_res = w_a | w_b;
            OP_XOR:        w_res = w_a ^ w_b;
            OP_SLL:        w_res = w_a << w_b[3:0];
            OP_SRL:        w_res = w_a >> w_b[3:0];
            OP_SRA:        w_res = $signed(w_a) >>> w_b[3:0];
            OP_SLT:        w_res = ($signed(w_a) < $signed(w_b)) ? 16'h0001 : 16'h0000;
            OP_LD, OP_ST:  w_res = w_a + w_b;
            OP_LI:         w_res = w_b;
            default:       w_res = 16'h0000;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_acc    <= 16'h0000;
            r_mcand  <= 16'h0000;
            r_mplier <= 16'h0000;
            r_dest   <= 3'd0;
            r_stv    <= 16'h0000;
            r_exbus  <= 40'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mul_req) begin
                        // Operands, dest and stvalue are latched so idbus is free to change.
                        r_mcand  <= w_a;
                        r_mplier <= w_b;
                        r_dest   <= w_dest;
                        r_stv    <= w_stv;
                        r_acc    <= 16'h0000;
                        r_cnt    <= 4'd0;
                        r_exbus  <= 40'h0;
                        r_state  <= BUSY;
                    end else if (w_vld) begin
                        r_exbus <= {1'b1, w_op, w_dest, w_res, w_stv};
                    end else begin
                        r_exbus <= 40'h0;
                    end
                end
                BUSY: begin
                    if (r_mplier[0])
                        r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 4'd1;
                    r_exbus  <= 40'h0;
                    if (r_cnt == 4'd15)
                        r_state <= DONE;
                end
                DONE: begin
                    r_exbus <= {1'b1, OP_MUL, r_dest, r_acc, r_stv};
                    r_state <= IDLE;
                end
                default: begin
                    r_exbus <= 40'h0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ex_module.sv
// Scoreboard bench for ex_module: directed vectors push expected exbus beats, a negedge monitor pops and compares.
module tb_ex_module;
    logic        clock;
    logic        resetn;
    logic [55:0] idbus;
    logic [39:0] exbus;
    logic [2:0]  ex_dest;
    logic        ex_stall;

    int total = 0;
    int bad   = 0;
    logic [39:0] exp_q[$];

    ex_module dut (
        .clock    (clock),
        .resetn   (resetn),
        .idbus    (idbus),
        .exbus    (exbus),
        .ex_dest  (ex_dest),
        .ex_stall (ex_stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [39:0] beat(input logic [3:0] op, input logic [2:0] d,
                                         input logic [15:0] r, input logic [15:0] s);
        return {1'b1, op, d, r, s};
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every cycle out of reset, a valid beat must match the queue head, otherwise exbus must be zero.
    always @(negedge clock) begin
        if (resetn) begin
            total++;
            if (exbus[39]) begin
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: got %h expected none", exbus);
                end else begin
                    logic [39:0] e;
                    e = exp_q.pop_front();
                    if (exbus !== e) begin
                        bad++;
                        $display("FAIL beat: got %h expected %h", exbus, e);
                    end
                end
            end else if (exbus !== 40'h0) begin
                bad++;
                $display("FAIL bubble: got %h expected 0", exbus);
            end
        end
    end

    task automatic issue(input string name, input logic [3:0] op, input logic [2:0] d,
                         input logic [15:0] a, input logic [15:0] b, input logic [15:0] s,
                         input logic [15:0] res);
        idbus = {1'b1, op, d, a, b, s};
        exp_q.push_back(beat(op, d, res, s));
        #1 check({name, "_stall"}, {39'h0, ex_stall}, 40'h0);
        @(posedge clock); #1;
    endtask

    task automatic issue_mul(input string name, input logic [2:0] d, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] s, input logic [15:0] res,
                             input bit scramble);
        int n;
        bit done;
        n = 0;
        done = 0;
        idbus = {1'b1, 4'b1001, d, a, b, s};
        exp_q.push_back(beat(4'b1001, d, res, s));
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clock);
            if (!ex_stall) begin
                done = 1;
            end else begin
                n++;
                @(posedge clock); #1;
                if (scramble)
                    idbus = {1'b1, 4'($urandom_range(0, 15)), 3'($urandom), 16'($urandom),
                             16'($urandom), 16'($urandom)};
            end
        end
        check({name, "_stall_cycles"}, 40'(n), 40'd17);
        @(posedge clock); #1;
    endtask

    initial begin
        resetn = 1'b0;
        idbus  = 56'h0;
        #1;
        check("reset_exbus", exbus, 40'h0);
        check("reset_stall", {39'h0, ex_stall}, 40'h0);
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;

        // ex_dest copies idbus dest even when not valid; invalid MUL must not stall.
        idbus = {1'b0, 4'b1001, 3'd5, 16'h0003, 16'h0005, 16'h0000};
        #1;
        check("ex_dest", {37'h0, ex_dest}, 40'd5);
        check("invalid_mul_stall", {39'h0, ex_stall}, 40'h0);
        @(posedge clock); #1;

        issue("add",  4'b0000, 3'd3, 16'hFFFF, 16'h0002, 16'h1234, 16'h0001);
        issue("st",   4'b1011, 3'd0, 16'h0100, 16'h0004, 16'hBEEF, 16'h0104);
        issue("sub",  4'b0001, 3'd1, 16'h0005, 16'h0007, 16'h0A0A, 16'hFFFE);
        issue("and",  4'b0010, 3'd2, 16'hF0F0, 16'h3C3C, 16'h0000, 16'h3030);
        issue("or",   4'b0011, 3'd4, 16'hF0F0, 16'h0F00, 16'h1111, 16'hFFF0);
        issue("xor",  4'b0100, 3'd5, 16'hFFFF, 16'h00FF, 16'h2222, 16'hFF00);
        issue("sll",  4'b0101, 3'd6, 16'h0001, 16'h0013, 16'h3333, 16'h0008);
        issue("srl",  4'b0110, 3'd7, 16'h8000, 16'h0004, 16'h4444, 16'h0800);
        issue("sra",  4'b0111, 3'd1, 16'h8000, 16'h0004, 16'h5555, 16'hF800);
        issue("slt1", 4'b1000, 3'd2, 16'hFFFF, 16'h0001, 16'h6666, 16'h0001);
        issue("slt0", 4'b1000, 3'd3, 16'h0001, 16'hFFFF, 16'h7777, 16'h0000);
        issue("ld",   4'b1010, 3'd4, 16'h1000, 16'h0010, 16'h8888, 16'h1010);
        issue("li",   4'b1100, 3'd5, 16'h9999, 16'hABCD, 16'h9999, 16'hABCD);
        issue("rsvd", 4'b1101, 3'd6, 16'h1234, 16'h5678, 16'hCAFE, 16'h0000);

        idbus = 56'h0;
        repeat (2) @(posedge clock);
        #1;

        issue_mul("mul_3x5", 3'd2, 16'h0003, 16'h0005, 16'hDEAD, 16'h000F, 1'b0);
        issue_mul("mul_ovf", 3'd3, 16'h1234, 16'h0100, 16'h0000, 16'h3400, 1'b1);
        issue_mul("mul_b2b", 3'd4, 16'h0007, 16'h0009, 16'h1111, 16'h003F, 1'b0);
        issue_mul("mul_ffff", 3'd5, 16'hFFFF, 16'hFFFF, 16'h2222, 16'h0001, 1'b0);
        issue("add_after_mul", 4'b0000, 3'd6, 16'h0010, 16'h0020, 16'h3333, 16'h0030);

        // Abort a MUL in BUSY iteration 8; it must never produce a beat.
        idbus = {1'b1, 4'b1001, 3'd7, 16'h0003, 16'h0005, 16'h0000};
        repeat (9) @(posedge clock);
        #1;
        check("busy_stall", {39'h0, ex_stall}, 40'h1);
        resetn = 1'b0;
        idbus  = 56'h0;
        #1;
        check("abort_stall", {39'h0, ex_stall}, 40'h0);
        check("abort_exbus", exbus, 40'h0);
        @(posedge clock); #1;
        resetn = 1'b1;
        issue("add_post_reset", 4'b0000, 3'd1, 16'h0001, 16'h0001, 16'h0000, 16'h0002);

        idbus = 56'h0;
        repeat (25) @(posedge clock);
        #1;
        check("queue_drained", 40'(exp_q.size()), 40'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
